// File: rtl/udp_port_word_packer_if.sv
// udp_port_word_packer_if: byte-in / word-out bus; slave = packer, master = byte source and word sink
interface udp_port_word_packer_if;
  logic [7:0]  i_port_byte;
  logic        i_port_byte_vld;
  logic        i_port_last_byte;
  logic        o_port_byte_rd;
  logic [31:0] o_word;
  logic        o_word_vld;
  logic        o_word_last;
  logic [2:0]  o_word_nbytes;
  logic        i_word_rdy;
  logic [15:0] o_pkt_cnt;
  modport slave (
    input  i_port_byte, i_port_byte_vld, i_port_last_byte, i_word_rdy,
    output o_port_byte_rd, o_word, o_word_vld, o_word_last, o_word_nbytes, o_pkt_cnt
  );
  modport master (
    output i_port_byte, i_port_byte_vld, i_port_last_byte, i_word_rdy,
    input  o_port_byte_rd, o_word, o_word_vld, o_word_last, o_word_nbytes, o_pkt_cnt
  );
endinterface

// File: rtl/udp_port_word_packer.sv
// udp_port_word_packer: packs FWFT payload bytes into 32-bit words (ports: i_rxmac_clk, i_rxmac_arst, bus slave; UDP_WORD_PACKER_PKT_CNT_EN enables o_pkt_cnt)
module udp_port_word_packer #(
  parameter int BIG_ENDIAN = 1
) (
  input logic i_rxmac_clk,
  input logic i_rxmac_arst,
  udp_port_word_packer_if.slave bus
);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state, state_n;
  logic [1:0] idx, idx_n, lane;
  logic [31:0] word, word_n;
  logic last, last_n;
  logic [2:0] nbytes, nbytes_n;
  logic consume, accept, fin;
  assign bus.o_port_byte_rd = bus.i_port_byte_vld & (state == COLLECT | bus.i_word_rdy) & ~i_rxmac_arst;
  assign bus.o_word = word;
  assign bus.o_word_vld = state == HOLD;
  assign bus.o_word_last = last;
  assign bus.o_word_nbytes = nbytes;
  always_comb begin
    consume = bus.o_port_byte_rd;
    accept = state == HOLD & bus.i_word_rdy;
    fin = consume & (idx == 2'd3 | bus.i_port_last_byte);
    lane = BIG_ENDIAN != 0 ? 2'd3 - idx : idx;
    state_n = fin ? HOLD : accept ? COLLECT : state;
    idx_n = fin ? 2'd0 : consume ? idx + 2'd1 : idx;
    word_n = consume ? ((idx == 2'd0 ? 32'd0 : word) | ({24'd0, bus.i_port_byte} << {lane, 3'b000})) : word;
    last_n = fin ? bus.i_port_last_byte : last;
    nbytes_n = fin ? {1'b0, idx} + 3'd1 : nbytes;
  end
  always_ff @(posedge i_rxmac_clk or posedge i_rxmac_arst) begin
    if (i_rxmac_arst) begin
      state <= COLLECT;
      idx <= '0;
      word <= '0;
      last <= 1'b0;
      nbytes <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      word <= word_n;
      last <= last_n;
      nbytes <= nbytes_n;
    end
  end
`ifdef UDP_WORD_PACKER_PKT_CNT_EN
  logic [15:0] pkt_cnt;
  always_ff @(posedge i_rxmac_clk or posedge i_rxmac_arst) begin
    if (i_rxmac_arst) pkt_cnt <= '0;
    else if (accept & last) pkt_cnt <= pkt_cnt + 16'd1;
  end
  assign bus.o_pkt_cnt = pkt_cnt;
`else
  assign bus.o_pkt_cnt = '0;
`endif
endmodule
